lfsr_rr_arbiter: RTL and testbench

- Shares one internal 8-bit Fibonacci LFSR among `NREQ` requesters.
- Grants are issued in fixed-length bursts, in round-robin order.
- Reseed requests are served only between bursts.
- Sits between the random-number source and consumers that each need private, non-overlapping byte streams (scramblers, test-pattern generators, backoff timers).

---
 rtl/lfsr_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_lfsr_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_arbiter.sv
// rtl/lfsr_rr_arbiter.sv - round-robin burst arbiter sharing one 8-bit Fibonacci LFSR
// Build option: LFSR_ARB_ZERO_GUARD_EN maps an accepted zero seed to 8'h01.
module lfsr_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            seed_vld,
  input  logic [7:0]      seed,
  output logic            seed_rdy,
  output logic [NREQ-1:0] gnt,
  output logic            rvalid,
  output logic [7:0]      rdata,
  output logic            busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(BURST - 1);
  localparam logic [PW-1:0]   PTR_LAST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [7:0]      lfsr_step;
  logic [7:0]      seed_load;
  logic [PW-1:0]   ptr_inc;
  logic [PW:0]     cand;
  logic [PW-1:0]   arb_idx;
  logic            arb_found;

  // Shift left, feedback from taps 7,5,4,3 (x^8+x^6+x^5+x^4+1).
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

`ifdef LFSR_ARB_ZERO_GUARD_EN
  // A zero seed would lock the LFSR, so substitute the reset value.
  assign seed_load = (seed == 8'h00) ? 8'h01 : seed;
`else
  assign seed_load = seed;
`endif

  // Pointer moves to the requester after the one just served.
  assign ptr_inc = (win_q == PTR_LAST) ? '0 : win_q + PW'(1);

  assign busy     = (state_q == S_BURST);
  assign seed_rdy = (state_q == S_IDLE);
  assign gnt      = gnt_q;
  assign rvalid   = busy && req[win_q];
  assign rdata    = lfsr_q;

  // Wrap-around search upward from the pointer; first asserted request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!arb_found && req[cand[PW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PW-1:0];
      end
    end
  end

  // Next-state logic: reseed or arbitrate in IDLE, deliver beats in BURST.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (seed_vld) begin
          lfsr_d = seed_load;
        end else if (arb_found) begin
          win_d   = arb_idx;
          gnt_d   = ONE_HOT0 << arb_idx;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (req[win_q]) begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_inc;
          end
        end else begin
          // Winner dropped its request: end the burst without a beat.
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// tb/tb_lfsr_rr_arbiter.sv - scoreboard bench for lfsr_rr_arbiter
module tb_lfsr_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            seed_vld;
  logic [7:0]      seed;
  logic            seed_rdy;
  logic [NREQ-1:0] gnt;
  logic            rvalid;
  logic [7:0]      rdata;
  logic            busy;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [7:0]      d;
  } beat_t;

  beat_t      exp_q[$];
  int         n_cmp;
  int         n_err;
  logic [7:0] m_lfsr;
  logic [7:0] zero_exp;

  lfsr_rr_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_vld(seed_vld), .seed(seed),
    .seed_rdy(seed_rdy), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [NREQ-1:0] g, input logic [7:0] d);
    beat_t b;
    b.g = g;
    b.d = d;
    exp_q.push_back(b);
  endtask

  task automatic push_burst(input logic [NREQ-1:0] g, input int n);
    for (int i = 0; i < n; i++) begin
      push1(g, m_lfsr);
      m_lfsr = lfsr_nx(m_lfsr);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: every delivered beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got gnt=%b data=%h expected no beat", gnt, rdata);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_gnt", 32'(gnt), 32'(b.g));
        chk("beat_data", 32'(rdata), 32'(b.d));
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    req      = '0;
    seed_vld = 1'b0;
    seed     = 8'h00;
`ifdef LFSR_ARB_ZERO_GUARD_EN
    zero_exp = 8'h01;
`else
    zero_exp = 8'h00;
`endif

    // Reset state
    #12;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_seed_rdy", 32'(seed_rdy), 32'h1);
    chk("rst_rdata", 32'(rdata), 32'h01);
    step();
    rst_n = 1'b1;

    // Single requester: two bursts separated by one IDLE cycle
    push1(4'b0001, 8'h01); push1(4'b0001, 8'h02);
    push1(4'b0001, 8'h04); push1(4'b0001, 8'h08);
    push1(4'b0001, 8'h11); push1(4'b0001, 8'h23);
    push1(4'b0001, 8'h47); push1(4'b0001, 8'h8E);
    req = 4'b0001;
    step();
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_first_rvalid", 32'(rvalid), 32'h1);
    repeat (BURST) step();
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_gnt", 32'(gnt), 32'h0);
    chk("t1_idle_rvalid", 32'(rvalid), 32'h0);
    step();
    chk("t1_gnt2", 32'(gnt), 32'b0001);
    repeat (BURST) step();
    req = '0;
    step();
    chk("t1_hold_busy", 32'(busy), 32'h0);

    // All requesters: round robin 0,1,2,3,0
    reset_pulse();
    m_lfsr = 8'h01;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      push_burst(4'(1 << (g % 4)), BURST);
      step();
      chk("t2_gnt", 32'(gnt), 32'(1 << (g % 4)));
      repeat (BURST) step();
      chk("t2_idle_busy", 32'(busy), 32'h0);
    end
    req = '0;

    // Pointer is 1: lone request 3 found by wrap search, pointer then 0
    req = 4'b1000;
    push_burst(4'b1000, BURST);
    step();
    chk("t3_wrap_gnt", 32'(gnt), 32'b1000);
    repeat (BURST) step();
    req = 4'b1111;
    push_burst(4'b0001, BURST);
    step();
    chk("t3_ptr0_gnt", 32'(gnt), 32'b0001);
    repeat (BURST) step();
    req = '0;

    // Abort after two beats
    reset_pulse();
    req = 4'b0001;
    push1(4'b0001, 8'h01); push1(4'b0001, 8'h02);
    step();
    step();
    step();
    req = '0;
    #1;
    chk("t4_abort_rvalid", 32'(rvalid), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h1);
    step();
    chk("t4_idle_busy", 32'(busy), 32'h0);
    chk("t4_idle_gnt", 32'(gnt), 32'h0);
    push1(4'b0001, 8'h04); push1(4'b0001, 8'h08);
    push1(4'b0001, 8'h11); push1(4'b0001, 8'h23);
    req = 4'b0001;
    step();
    chk("t4_gnt", 32'(gnt), 32'b0001);
    repeat (BURST) step();
    req = '0;

    // Reseed held off mid-burst, then wins over a pending request
    m_lfsr = 8'h47;
    req = 4'b0010;
    push_burst(4'b0010, BURST);
    step();
    step();
    seed_vld = 1'b1;
    seed = 8'hA5;
    #1;
    chk("t5_rdy_mid", 32'(seed_rdy), 32'h0);
    step();
    chk("t5_rdy_mid2", 32'(seed_rdy), 32'h0);
    step();
    step();
    chk("t5_rdy_idle", 32'(seed_rdy), 32'h1);
    step();
    seed_vld = 1'b0;
    chk("t5_reseed_busy", 32'(busy), 32'h0);
    chk("t5_reseed_gnt", 32'(gnt), 32'h0);
    chk("t5_reseed_val", 32'(rdata), 32'hA5);
    push1(4'b0010, 8'hA5); push1(4'b0010, 8'h4A);
    m_lfsr = lfsr_nx(8'h4A);
    push_burst(4'b0010, BURST - 2);
    step();
    chk("t5_gnt", 32'(gnt), 32'b0010);
    repeat (BURST) step();
    req = '0;

    // Zero seed
    seed_vld = 1'b1;
    seed = 8'h00;
    step();
    seed_vld = 1'b0;
    chk("t6_zero_val", 32'(rdata), 32'(zero_exp));
    m_lfsr = zero_exp;
    req = 4'b0001;
    push_burst(4'b0001, BURST);
    step();
    chk("t6_gnt", 32'(gnt), 32'b0001);
    repeat (BURST) step();
    req = '0;

    // Asynchronous reset mid-burst
    req = 4'b0100;
    push_burst(4'b0100, 1);
    step();
    chk("t7_gnt", 32'(gnt), 32'b0100);
    step();
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("t7_rst_gnt", 32'(gnt), 32'h0);
    chk("t7_rst_rvalid", 32'(rvalid), 32'h0);
    chk("t7_rst_busy", 32'(busy), 32'h0);
    chk("t7_rst_seed_rdy", 32'(seed_rdy), 32'h1);
    chk("t7_rst_rdata", 32'(rdata), 32'h01);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
